// File: rtl/store_narrow.sv
// store_narrow: narrows a 32-bit register value into a word-only DM for sw/sh/sb.
// Sub-word stores use read-modify-write; optional byte-enable path via
// STORE_NARROW_BYTE_EN_EN (adds mem_be, all stores complete in one write).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req, SOp, addr,     : store request, op (00 sw, 01 sh, 10 sb, 11 rsvd),
//   wdata               : byte address and register value (captured in IDLE)
//   busy, done, err     : status (registered)
//   mem_addr, mem_re,   : DM word address, read strobe,
//   mem_rdata           : read data (valid the cycle after mem_re)
//   mem_we, mem_wdata   : DM write strobe and data
//   mem_be              : byte enables (only with STORE_NARROW_BYTE_EN_EN)
module store_narrow #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        SOp,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
`ifdef STORE_NARROW_BYTE_EN_EN
    output logic [3:0]        mem_be,
`endif
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;
    localparam logic [1:0] OP_RS = 2'b11;

    state_t             r_state;
    state_t             w_state_n;

    logic [1:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;

    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [ADDR_W-3:0]  r_mem_addr;
    logic               r_mem_re;
    logic               r_mem_we;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_be;

    logic               w_capture;
    logic               w_bad;
    logic [31:0]        w_wr_word;
    logic [3:0]         w_wr_be;
    logic               w_busy_n;
    logic               w_done_n;
    logic               w_err_n;
    logic [ADDR_W-3:0]  w_mem_addr_n;
    logic               w_mem_re_n;
    logic               w_mem_we_n;
    logic [31:0]        w_mem_wdata_n;
    logic [3:0]         w_mem_be_n;

    // Address bits above ADDR_W-1 are deliberately ignored.
    logic               w_unused_addr;
`ifdef STORE_NARROW_BYTE_EN_EN
    logic               w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata;
`endif
    assign w_unused_addr = ^addr[31:ADDR_W];

    assign w_capture = (r_state == S_IDLE) && req;

    assign w_bad = (SOp == OP_RS)
                || ((SOp == OP_SW) && (addr[1:0] != 2'b00))
                || ((SOp == OP_SH) && addr[0]);

    // Word presented on the final write: merged RMW word, or the
    // lane-replicated value when the DM takes byte enables.
    always_comb begin
        w_wr_word = r_wdata;
        w_wr_be   = 4'b1111;
`ifdef STORE_NARROW_BYTE_EN_EN
        unique case (r_op)
            OP_SB: begin
                w_wr_word = {4{r_wdata[7:0]}};
                w_wr_be   = 4'b0001 << r_addr[1:0];
            end
            OP_SH: begin
                w_wr_word = {2{r_wdata[15:0]}};
                w_wr_be   = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wr_word = r_wdata;
                w_wr_be   = 4'b1111;
            end
        endcase
`else
        unique case (r_op)
            OP_SB: begin
                w_wr_word = mem_rdata;
                w_wr_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            OP_SH: begin
                w_wr_word = mem_rdata;
                if (r_addr[1])
                    w_wr_word[31:16] = r_wdata[15:0];
                else
                    w_wr_word[15:0] = r_wdata[15:0];
            end
            default: w_wr_word = r_wdata;
        endcase
`endif
    end

    // Next state. r_state describes the cycle before the outputs it drives,
    // so every output can be registered off it.
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_bad)
                        w_state_n = S_ERR;
`ifdef STORE_NARROW_BYTE_EN_EN
                    else
                        w_state_n = S_WRITE;
`else
                    else if (SOp == OP_SW)
                        w_state_n = S_WRITE;
                    else
                        w_state_n = S_READ;
`endif
                end
            end
            S_READ:  w_state_n = S_WAIT;
            S_WAIT:  w_state_n = S_WRITE;
            S_WRITE: w_state_n = S_IDLE;
            S_ERR:   w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Next registered outputs.
    always_comb begin
        w_busy_n      = (r_state != S_IDLE);
        w_mem_addr_n  = '0;
        w_mem_re_n    = (r_state == S_READ);
        w_mem_we_n    = (r_state == S_WRITE);
        w_done_n      = (r_state == S_WRITE);
        w_err_n       = (r_state == S_ERR);
        w_mem_wdata_n = '0;
        w_mem_be_n    = '0;
        if (r_state != S_IDLE)
            w_mem_addr_n = r_addr[ADDR_W-1:2];
        if (r_state == S_WRITE) begin
            w_mem_wdata_n = w_wr_word;
            w_mem_be_n    = w_wr_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_state     <= w_state_n;
            if (w_capture) begin
                r_op    <= SOp;
                r_addr  <= addr[ADDR_W-1:0];
                r_wdata <= wdata;
            end
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_err       <= w_err_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_re    <= w_mem_re_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_mem_be    <= w_mem_be_n;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
`ifdef STORE_NARROW_BYTE_EN_EN
    assign mem_be    = r_mem_be;
`else
    logic w_unused_be;
    assign w_unused_be = ^r_mem_be;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Directed testbench for store_narrow.
// Outputs are sampled 1 time unit after the rising edge.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  SOp = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;
    logic        mem_we;
    logic [31:0] mem_wdata;
`ifdef STORE_NARROW_BYTE_EN_EN
    logic [3:0]  mem_be;
`endif

    logic [31:0] rd_word = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    store_narrow #(.ADDR_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .SOp       (SOp),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
`ifdef STORE_NARROW_BYTE_EN_EN
        .mem_be    (mem_be),
`endif
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    // Single-word DM read model: data valid the cycle after mem_re.
    always @(posedge clk)
        if (mem_re) mem_rdata <= rd_word;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request captured at the next edge (E0); returns in cycle 0.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        SOp = op;
        addr = a;
        wdata = d;
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({busy, done, err, mem_re, mem_we} !== 5'b0) begin
            $display("FAIL reset_flags got=%b exp=00000",
                     {busy, done, err, mem_re, mem_we});
            n_fail++;
        end
        n_tests++;
        if (mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
            $display("FAIL reset_bus got addr=%0d wd=%h exp 0/0",
                     mem_addr, mem_wdata);
            n_fail++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sw();
        issue(2'b00, 32'h10, 32'hDEADBEEF);
        tick();
        n_tests++;
        if ({busy, done, mem_we, mem_re, err} !== 5'b11100) begin
            $display("FAIL sw_c1_flags got=%b exp=11100",
                     {busy, done, mem_we, mem_re, err});
            n_fail++;
        end
        n_tests++;
        if (mem_addr !== 10'd4 || mem_wdata !== 32'hDEADBEEF) begin
            $display("FAIL sw_c1_bus got addr=%0d wd=%h exp 4/deadbeef",
                     mem_addr, mem_wdata);
            n_fail++;
        end
`ifdef STORE_NARROW_BYTE_EN_EN
        n_tests++;
        if (mem_be !== 4'b1111) begin
            $display("FAIL sw_be got=%b exp=1111", mem_be);
            n_fail++;
        end
`endif
        tick();
        n_tests++;
        if ({busy, done, mem_we, mem_addr} !== 13'd0) begin
            $display("FAIL sw_c2_idle got=%b exp=0",
                     {busy, done, mem_we, mem_addr});
            n_fail++;
        end
    endtask

`ifndef STORE_NARROW_BYTE_EN_EN
    // Runs a sh/sb RMW against rd_word and checks the full 3-cycle sequence.
    task automatic rmw_case(input string nm, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_w);
        rd_word = 32'h11223344;
        issue(op, a, d);
        tick();
        n_tests++;
        if ({busy, mem_re, mem_we, done} !== 4'b1100 || mem_addr !== 10'd4) begin
            $display("FAIL %s_c1 got=%b addr=%0d exp=1100 addr=4",
                     nm, {busy, mem_re, mem_we, done}, mem_addr);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({busy, mem_re, mem_we, done} !== 4'b1000 || mem_addr !== 10'd4) begin
            $display("FAIL %s_c2 got=%b addr=%0d exp=1000 addr=4",
                     nm, {busy, mem_re, mem_we, done}, mem_addr);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({busy, mem_re, mem_we, done} !== 4'b1011 || mem_wdata !== exp_w) begin
            $display("FAIL %s_c3 got=%b wd=%h exp=1011 wd=%h",
                     nm, {busy, mem_re, mem_we, done}, mem_wdata, exp_w);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({busy, mem_we, done} !== 3'b000) begin
            $display("FAIL %s_c4 got=%b exp=000", nm, {busy, mem_we, done});
            n_fail++;
        end
    endtask

    task automatic test_sb();
        rmw_case("sb12", 2'b10, 32'h12, 32'h000000AB, 32'h11AB3344);
        rmw_case("sb13", 2'b10, 32'h13, 32'h000000CD, 32'hCD223344);
    endtask

    task automatic test_sh();
        rmw_case("sh12", 2'b01, 32'h12, 32'hFFFF5566, 32'h55663344);
        rmw_case("sh10", 2'b01, 32'h10, 32'hFFFF5566, 32'h11225566);
    endtask

    task automatic test_reset_mid();
        int we_seen;
        we_seen = 0;
        rd_word = 32'h11223344;
        issue(2'b10, 32'h12, 32'h000000AB);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({busy, done, err, mem_re, mem_we} !== 5'b0 ||
            mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
            $display("FAIL rst_mid got=%b addr=%0d wd=%h exp all 0",
                     {busy, done, err, mem_re, mem_we}, mem_addr, mem_wdata);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_we) we_seen++;
        end
        n_tests++;
        if (we_seen !== 0) begin
            $display("FAIL rst_mid_nowe got=%0d exp=0", we_seen);
            n_fail++;
        end
        test_sw();
    endtask

    task automatic test_req_during_busy();
        int n_done;
        n_done = 0;
        rd_word = 32'h00000000;
        issue(2'b10, 32'h10, 32'h00000077);
        tick();
        if (done) n_done++;
        req = 1'b1;
        tick();
        req = 1'b0;
        if (done) n_done++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) n_done++;
        end
        n_tests++;
        if (n_done !== 1) begin
            $display("FAIL req_busy_dones got=%0d exp=1", n_done);
            n_fail++;
        end
    endtask
`endif

    task automatic err_case(input string nm, input logic [1:0] op,
                            input logic [31:0] a);
        int strobes;
        strobes = 0;
        issue(op, a, 32'h12345678);
        if (mem_re || mem_we) strobes++;
        tick();
        n_tests++;
        if ({err, done, busy} !== 3'b101) begin
            $display("FAIL %s_c1 got=%b exp=101", nm, {err, done, busy});
            n_fail++;
        end
        if (mem_re || mem_we) strobes++;
        tick();
        n_tests++;
        if ({err, done, busy} !== 3'b000) begin
            $display("FAIL %s_c2 got=%b exp=000", nm, {err, done, busy});
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            if (mem_re || mem_we) strobes++;
            tick();
        end
        n_tests++;
        if (strobes !== 0) begin
            $display("FAIL %s_strobes got=%0d exp=0", nm, strobes);
            n_fail++;
        end
    endtask

    task automatic test_err();
        err_case("err_sh13", 2'b01, 32'h13);
        err_case("err_sw11", 2'b00, 32'h11);
        err_case("err_rsvd", 2'b11, 32'h10);
    endtask

    // req held across a sw: ignored at E1, recaptured at E2.
    task automatic test_back_to_back();
        SOp = 2'b00;
        addr = 32'h20;
        wdata = 32'hCAFEF00D;
        req = 1'b1;
        tick();
        tick();
        n_tests++;
        if (done !== 1'b1 || mem_addr !== 10'd8 || mem_wdata !== 32'hCAFEF00D) begin
            $display("FAIL b2b_c1 got done=%b addr=%0d wd=%h exp 1/8/cafef00d",
                     done, mem_addr, mem_wdata);
            n_fail++;
        end
        addr = 32'h24;
        wdata = 32'h0BADC0DE;
        tick();
        req = 1'b0;
        n_tests++;
        if ({busy, done, mem_we} !== 3'b000) begin
            $display("FAIL b2b_gap got=%b exp=000", {busy, done, mem_we});
            n_fail++;
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || mem_addr !== 10'd9 || mem_wdata !== 32'h0BADC0DE) begin
            $display("FAIL b2b_c3 got done=%b addr=%0d wd=%h exp 1/9/0badc0de",
                     done, mem_addr, mem_wdata);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL b2b_end got=%b exp=00", {busy, done});
            n_fail++;
        end
    endtask

`ifdef STORE_NARROW_BYTE_EN_EN
    task automatic be_case(input string nm, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_w, input logic [3:0] exp_be);
        int re_seen;
        re_seen = 0;
        issue(op, a, d);
        tick();
        if (mem_re) re_seen++;
        n_tests++;
        if ({done, mem_we} !== 2'b11 || mem_be !== exp_be || mem_wdata !== exp_w) begin
            $display("FAIL %s_c1 got=%b be=%b wd=%h exp=11 be=%b wd=%h",
                     nm, {done, mem_we}, mem_be, mem_wdata, exp_be, exp_w);
            n_fail++;
        end
        tick();
        if (mem_re) re_seen++;
        n_tests++;
        if ({busy, mem_we} !== 2'b00 || mem_be !== 4'b0000 || re_seen !== 0) begin
            $display("FAIL %s_c2 got=%b be=%b re=%0d exp=00 be=0000 re=0",
                     nm, {busy, mem_we}, mem_be, re_seen);
            n_fail++;
        end
    endtask

    task automatic test_byte_en();
        be_case("be_sb11", 2'b10, 32'h11, 32'h0000007F, 32'h7F7F7F7F, 4'b0010);
        be_case("be_sb13", 2'b10, 32'h13, 32'h000000A5, 32'hA5A5A5A5, 4'b1000);
        be_case("be_sh12", 2'b01, 32'h12, 32'hFFFF5566, 32'h55665566, 4'b1100);
        be_case("be_sh10", 2'b01, 32'h10, 32'h00001234, 32'h12341234, 4'b0011);
    endtask
`endif

    initial begin
        test_reset();
        test_sw();
`ifndef STORE_NARROW_BYTE_EN_EN
        test_sb();
        test_sh();
`else
        test_byte_en();
`endif
        test_err();
`ifndef STORE_NARROW_BYTE_EN_EN
        test_reset_mid();
        test_req_during_busy();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Store-path counterpart of the immediate/data extender. Takes a 32-bit register value and narrows it into a word-only data memory for sw/sh/sb.
- Sub-word stores use a read-modify-write sequence: read the word, merge the byte or half lane, write it back.
- Sits between the datapath store request and the DM.
- Multi-cycle. The controller stalls on `busy`.

Parameters:
- ADDR_W, 12, byte-address bits used. The DM word address is addr[ADDR_W-1:2].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- req  input  1  store request, sampled only in IDLE
- SOp  input  2  00 sw, 01 sh, 10 sb, 11 reserved
- addr  input  32  byte address
- wdata  input  32  register value to store
- busy  output  1  high from the cycle after capture until the cycle after done/err
- done  output  1  one-cycle pulse, coincident with the final write
- err  output  1  one-cycle pulse on misalignment or reserved SOp
- mem_addr  output  ADDR_W-2  DM word address
- mem_re  output  1  DM read strobe
- mem_rdata  input  32  DM read data, valid in the cycle after mem_re
- mem_we  output  1  DM write strobe
- mem_wdata  output  32  DM write data

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, internal latches 0.
- Registering: all outputs are registered. Nothing is driven combinationally from inputs.
- Capture: in IDLE, req=1 at edge E0 latches SOp, addr, wdata. "Cycle n" means the cycle after edge En.
- req is ignored while busy=1. A request must be held or re-issued after busy falls.
- States: IDLE, READ, WAIT, WRITE, ERR.
- Error check (at capture):
  - err if SOp=11, or sw with addr[1:0]!=0, or sh with addr[0]=1.
  - Transition to ERR. err=1 in cycle 1, no mem_re/mem_we ever, then IDLE.
- sw: transition to WRITE. In cycle 1: mem_we=1, mem_wdata=wdata, done=1. Then IDLE. Latency 1.
- sh/sb, cycle 1 (READ): mem_re=1, mem_addr=addr[ADDR_W-1:2].
- sh/sb, cycle 2 (WAIT): mem_rdata valid; merged word registered at E3.
- sh/sb, cycle 3 (WRITE): mem_we=1, mem_wdata=merged, done=1. Then IDLE. Latency 3.
- sb merge: lane k=addr[1:0]; bits [8k+7:8k] ← wdata[7:0]; other bytes keep mem_rdata.
- sh merge: addr[1]=0 → [15:0] ← wdata[15:0]; addr[1]=1 → [31:16] ← wdata[15:0].
- mem_addr holds for the whole transaction and is 0 in IDLE.
- busy is high in cycles 1..latency. In ERR, busy is high in cycle 1 only.
- Back-to-back: a new req can be captured on the edge ending the done/err cycle. busy is then 0 in that cycle; the next capture starts a new transaction.
- Reset mid-operation (any state): next cycle IDLE, all outputs 0. A pending write is never issued; a partial RMW leaves memory unmodified.
- addr bits above ADDR_W-1 are ignored; no range error.

Optional Feature:
- Macro: STORE_NARROW_BYTE_EN_EN.
- Defined:
  - Adds output mem_be[3:0]; the DM is assumed to support byte-enable writes. No RMW.
  - sh/sb complete like sw: cycle 1, mem_we=1, done=1.
  - sb: mem_wdata = wdata[7:0] replicated ×4, mem_be = one-hot lane.
  - sh: mem_wdata = wdata[15:0] replicated ×2, mem_be = 0011 or 1100.
  - sw: mem_be=1111.
  - mem_be=0 when mem_we=0; error rules unchanged.
- Undefined: no mem_be port; RMW behaviour as above.

Test Plan:
- sw addr=0x10 wdata=0xDEADBEEF → cycle 1: mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, done=1; cycle 2: busy=0.
- Memory word 4 = 0x11223344; sb addr=0x12 wdata=0x000000AB → cycle 1: mem_re=1; cycle 3: mem_we=1, mem_wdata=0x11AB3344, done=1.
- Same memory; sh addr=0x12 wdata=0xFFFF5566 → cycle 3: mem_wdata=0x55663344. sh addr=0x10 → 0x11225566.
- sh addr=0x13, sw addr=0x11, SOp=11 each → err=1 in cycle 1, done=0, mem_re=mem_we=0 throughout.
- sb started, reset=1 in cycle 2 → cycle 3: all outputs 0, no mem_we; a following sw completes normally. Also: req pulsed during busy is ignored (exactly one done).
- With STORE_NARROW_BYTE_EN_EN: sb addr=0x11 wdata=0x7F → cycle 1: mem_be=0010, mem_wdata=0x7F7F7F7F, done=1, mem_re never asserted.
